// File: rtl/md_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Operands are latched on start; HI/LO are committed atomically when the counter expires.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);

    localparam int unsigned W2      = 2 * WIDTH;
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;

    logic               long_req_c;
    logic               signed_op_c;
    logic               is_mul_c;
    logic               commit_en_c;
    logic [W2-1:0]      a_ext_c;
    logic [W2-1:0]      b_ext_c;
    logic [W2-1:0]      product_c;
    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH-1:0]   q_mag_c;
    logic [WIDTH-1:0]   r_mag_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;
    logic [WIDTH-1:0]   res_hi_c;
    logic [WIDTH-1:0]   res_lo_c;

    // Requests that will occupy the unit for more than one cycle.
    assign long_req_c = bus.start &&
                        ((bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                         (bus.op == OP_DIV)  || (bus.op == OP_DIVU));

    assign bus.stall_req = busy_q | long_req_c;
    assign bus.busy      = busy_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // Result datapath, evaluated from the latched operands.
    always_comb begin
        signed_op_c = (op_q == OP_MULT) || (op_q == OP_DIV);
        is_mul_c    = (op_q == OP_MULT) || (op_q == OP_MULTU);

        // One 2W-bit multiplier serves both flavours; sign extension selects signedness.
        a_ext_c   = signed_op_c ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext_c   = signed_op_c ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product_c = a_ext_c * b_ext_c;

        // Magnitude division; MIN / -1 falls out as quotient MIN, remainder 0.
        a_neg_c = signed_op_c && a_q[WIDTH-1];
        b_neg_c = signed_op_c && b_q[WIDTH-1];
        a_mag_c = a_neg_c ? (WIDTH'(0) - a_q) : a_q;
        b_mag_c = b_neg_c ? (WIDTH'(0) - b_q) : b_q;
        q_mag_c = '0;
        r_mag_c = '0;
        if (b_mag_c != '0) begin
            q_mag_c = a_mag_c / b_mag_c;
            r_mag_c = a_mag_c % b_mag_c;
        end
        quo_c = (a_neg_c ^ b_neg_c) ? (WIDTH'(0) - q_mag_c) : q_mag_c;
        rem_c = a_neg_c ? (WIDTH'(0) - r_mag_c) : r_mag_c;

        res_hi_c    = is_mul_c ? product_c[W2-1:WIDTH] : rem_c;
        res_lo_c    = is_mul_c ? product_c[WIDTH-1:0]  : quo_c;
        commit_en_c = is_mul_c || (b_q != '0);
    end

    // Control FSM, operand latches and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            op_q   <= OP_NONE;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                op_q   <= bus.op;
                                a_q    <= bus.a;
                                b_q    <= bus.b;
                                cnt    <= CNT_W'(MULT_CYCLES - 1);
                                busy_q <= 1'b1;
                                state  <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q   <= bus.op;
                                a_q    <= bus.a;
                                b_q    <= bus.b;
                                cnt    <= CNT_W'(DIV_CYCLES - 1);
                                busy_q <= 1'b1;
                                state  <= RUN;
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Requests arriving here are dropped; the stall controller prevents them.
                    if (cnt == '0) begin
                        if (commit_en_c) begin
                            hi_q <= res_hi_c;
                            lo_q <= res_lo_c;
                        end
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes reference HI/LO results, monitor checks on commit.
module tb_md_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        bit          mt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(W)) bus();

    md_unit #(
        .WIDTH(W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int          compared = 0;
    int          mismatched = 0;
    exp_t        sbq[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 64-bit integer arithmetic on the architectural operands.
    task automatic push_expect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit use_k, input logic [31:0] k_hi, input logic [31:0] k_lo);
        exp_t            e;
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin sp = sa * sb; m_hi = 32'(sp >>> 32); m_lo = 32'(sp); end
            3'd2: begin up = ua * ub; m_hi = 32'(up >> 32); m_lo = 32'(up); end
            3'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            3'd4: if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
        if (use_k) begin
            m_hi = k_hi;
            m_lo = k_lo;
        end
        e.hi     = m_hi;
        e.lo     = m_lo;
        e.mt     = (op == 3'd5) || (op == 3'd6);
        e.cycles = (op == 3'd1 || op == 3'd2) ? int'(MC) : (op == 3'd3 || op == 3'd4) ? int'(DC) : 0;
        if (op >= 3'd1 && op <= 3'd6) sbq.push_back(e);
    endtask

    // Called at a negedge; start is held for exactly one rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit use_k, input logic [31:0] k_hi, input logic [31:0] k_lo);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        push_expect(op, a, b, use_k, k_hi, k_lo);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait for busy to drop, optionally throwing illegal requests at the unit meanwhile.
    task automatic wait_idle(input int inject_pct, input bit force_mtlo);
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (force_mtlo && n == 0) begin
                bus.start = 1'b1;
                bus.op    = 3'd6;
                bus.a     = 32'hDEAD_BEEF;
            end else if (int'($urandom_range(99)) < inject_pct) begin
                bus.start = 1'b1;
                bus.op    = 3'($urandom_range(7));
                bus.a     = $urandom;
                bus.b     = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (n >= 200) chk("busy_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    // Monitor: capture what the edge saw, then check just after the following negedge.
    logic        rst_ev = 1'b0;
    logic        mt_ev = 1'b0;
    bit          armed = 1'b0;
    bit          prev_busy = 1'b0;
    int          bcnt = 0;
    logic [31:0] mon_hi = '0;
    logic [31:0] mon_lo = '0;
    logic        exp_stall;
    exp_t        got;

    always @(posedge clk) begin
        rst_ev <= reset;
        mt_ev  <= !reset && bus.start && (bus.busy === 1'b0) &&
                  ((bus.op == 3'd5) || (bus.op == 3'd6));
    end

    always begin
        @(negedge clk);
        #1;
        if (rst_ev) begin
            armed     = 1'b1;
            bcnt      = 0;
            prev_busy = 1'b0;
            mon_hi    = '0;
            mon_lo    = '0;
            chk("reset_busy", {31'd0, bus.busy}, 32'd0);
            chk("reset_hi", bus.hi, 32'd0);
            chk("reset_lo", bus.lo, 32'd0);
        end else if (armed) begin
            exp_stall = bus.busy | (bus.start && bus.op >= 3'd1 && bus.op <= 3'd4);
            chk("stall_req", {31'd0, bus.stall_req}, {31'd0, exp_stall});
            if (bus.busy === 1'b1) bcnt++;
            if (mt_ev || (prev_busy && bus.busy === 1'b0)) begin
                if (sbq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_commit: hi 0x%08h lo 0x%08h with empty scoreboard at %0t",
                             bus.hi, bus.lo, $time);
                end else begin
                    got = sbq.pop_front();
                    chk("result_hi", bus.hi, got.hi);
                    chk("result_lo", bus.lo, got.lo);
                    if (got.mt) chk("mt_busy", {31'd0, bus.busy}, 32'd0);
                    else        chk("busy_cycles", 32'(bcnt), 32'(got.cycles));
                    mon_hi = got.hi;
                    mon_lo = got.lo;
                end
                bcnt = 0;
            end else begin
                chk("hi_hold", bus.hi, mon_hi);
                chk("lo_hold", bus.lo, mon_lo);
            end
            prev_busy = (bus.busy === 1'b1);
        end
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // DIV aborted by reset mid-flight: nothing may be committed.
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        m_hi = '0;
        m_lo = '0;

        issue(3'd5, 32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234, 32'h0);
        wait_idle(0, 1'b0);
        issue(3'd1, 32'hFFFF_FFFE, 32'h3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_idle(0, 1'b1);
        issue(3'd2, 32'hFFFF_FFFE, 32'h3, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
        wait_idle(0, 1'b0);
        issue(3'd3, 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_idle(0, 1'b0);
        issue(3'd5, 32'h11, 32'd0, 1'b1, 32'h11, 32'hFFFF_FFFD);
        wait_idle(0, 1'b0);
        issue(3'd6, 32'h22, 32'd0, 1'b1, 32'h11, 32'h22);
        wait_idle(0, 1'b0);
        issue(3'd4, 32'h7, 32'h0, 1'b1, 32'h11, 32'h22);
        wait_idle(0, 1'b0);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000);
        wait_idle(0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            rop = 3'($urandom_range(7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(40)); rb = 32'($urandom_range(9)); end
                3: begin ra = 32'd0 - 32'($urandom_range(40)); rb = 32'($urandom_range(9)); end
                default: ;
            endcase
            issue(rop, ra, rb, 1'b0, 32'd0, 32'd0);
            wait_idle(10, 1'b0);
        end

        wait_idle(0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
